uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_parser_pkg.sv | 54 +++++
 rtl/uart_cmd_parser_if.sv | 27 ++
 rtl/uart_cmd_parser_resp_buf.sv | 41 ++++
 rtl/uart_cmd_parser.sv | 147 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared ASCII constants, parser state encoding and hex conversion helpers
// for the UART register command parser.
package uart_cmd_pkg;

  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_W     = 8'h57;
  localparam logic [7:0] CH_K     = 8'h4B;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CASE_BIT = 8'h20;

  localparam logic [31:0] RESP_K = {CH_K, CR, LF, 8'h00};
  localparam logic [31:0] RESP_E = {CH_E, CR, LF, 8'h00};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_EOL,
    ST_DISCARD,
    ST_EXEC,
    ST_RDWAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } nib_t;

  function automatic nib_t hex_to_nib(input logic [7:0] c);
    nib_t r;
    r.vld = 1'b1;
    r.nib = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)
      r.nib = c[3:0];
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r.nib = c[3:0] + 4'd9;
    else
      r.vld = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : {4'h4, n - 4'd9};
  endfunction

  // Accepts the upper-case command letter and its lower-case twin.
  function automatic logic is_cmd(input logic [7:0] c, input logic [7:0] up);
    return (c == up) || (c == (up | CASE_BIT));
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream handshakes and register bus seen by the command parser.
interface uart_cmd_parser_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    input  rx_data, rx_valid, tx_ready, reg_rdata,
    output rx_ready, tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, reg_rdata,
    input  rx_ready, tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/uart_cmd_parser_resp_buf.sv
// Up-to-4-byte response buffer: loaded in parallel, drained MSB-first over
// the tx valid/ready handshake; done marks the final byte's handshake.
module uart_cmd_resp_buf
  import uart_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_cnt,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);
  logic [31:0] shreg;
  logic [2:0]  cnt;
  logic        hs;

  assign tx_valid = (cnt != 3'd0) && !rst;
  assign tx_data  = shreg[31:24];
  assign hs       = tx_valid && tx_ready;
  assign done     = hs && (cnt == 3'd1);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 3'd0;
    else if (load)
      cnt <= load_cnt;
    else if (hs)
      cnt <= cnt - 3'd1;
  end

  // Byte storage carries no reset; cnt alone decides what is valid.
  always_ff @(posedge clk) begin
    if (load)
      shreg <= load_data;
    else if (hs)
      shreg <= {shreg[23:0], 8'h00};
  end
endmodule

// File: rtl/uart_cmd_parser.sv
// Line-based ASCII register command parser: "R"AA"\n" reads, "W"AADD"\n"
// writes, answering "K", the read value in hex, or "E" for malformed lines.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic               clk_48mhz,
  input  logic               reset,
  uart_cmd_parser_if.master  bus
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic              dcnt, dcnt_nxt;
  logic              is_wr, is_wr_nxt;
  logic              rx_rdy, rx_fire, rx_cr, rx_lf;
  logic              we_c, re_c;
  logic              load;
  logic [31:0]       load_data;
  logic [2:0]        load_cnt;
  logic              resp_done;
  nib_t              nib;

  assign rx_rdy  = !reset && (state == ST_IDLE || state == ST_ADDR || state == ST_DATA ||
                              state == ST_EOL  || state == ST_DISCARD);
  assign rx_fire = bus.rx_valid && rx_rdy;
  assign rx_cr   = rx_fire && (bus.rx_data == CR);
  assign rx_lf   = rx_fire && (bus.rx_data == LF);
  assign nib     = hex_to_nib(bus.rx_data);

  assign bus.rx_ready  = rx_rdy;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_c && !reset;
  assign bus.reg_re    = re_c && !reset;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      dcnt    <= 1'b0;
      is_wr   <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      dcnt    <= dcnt_nxt;
      is_wr   <= is_wr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    dcnt_nxt  = dcnt;
    is_wr_nxt = is_wr;
    we_c      = 1'b0;
    re_c      = 1'b0;
    load      = 1'b0;
    load_data = RESP_E;
    load_cnt  = 3'd3;
    case (state)
      ST_IDLE: begin
        if (rx_fire && !rx_cr && !rx_lf) begin
          dcnt_nxt = 1'b0;
          if (is_cmd(bus.rx_data, CH_R)) begin
            is_wr_nxt = 1'b0;
            state_nxt = ST_ADDR;
          end else if (is_cmd(bus.rx_data, CH_W)) begin
            is_wr_nxt = 1'b1;
            state_nxt = ST_ADDR;
          end else begin
            state_nxt = ST_DISCARD;
          end
        end
      end
      ST_ADDR, ST_DATA: begin
        if (rx_lf) begin
          load      = 1'b1;
          state_nxt = ST_RESP;
        end else if (rx_fire && !rx_cr) begin
          if (!nib.vld) begin
            state_nxt = ST_DISCARD;
          end else begin
            if (state == ST_ADDR)
              addr_nxt = {addr_q[ADDR_W-5:0], nib.nib};
            else
              wdata_nxt = {wdata_q[DATA_W-5:0], nib.nib};
            dcnt_nxt = ~dcnt;
            if (dcnt)
              state_nxt = (state == ST_ADDR && is_wr) ? ST_DATA : ST_EOL;
          end
        end
      end
      ST_EOL: begin
        if (rx_lf)
          state_nxt = ST_EXEC;
        else if (rx_fire && !rx_cr)
          state_nxt = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (rx_lf) begin
          load      = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_EXEC: begin
        if (is_wr) begin
          we_c      = 1'b1;
          load      = 1'b1;
          load_data = RESP_K;
          state_nxt = ST_RESP;
        end else begin
          re_c      = 1'b1;
          state_nxt = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        load      = 1'b1;
        load_data = {nib_to_hex(bus.reg_rdata[7:4]), nib_to_hex(bus.reg_rdata[3:0]), CR, LF};
        load_cnt  = 3'd4;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (resp_done)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  uart_cmd_resp_buf u_resp_buf (
    .clk       (clk_48mhz),
    .rst       (reset),
    .load      (load),
    .load_data (load_data),
    .load_cnt  (load_cnt),
    .tx_data   (bus.tx_data),
    .tx_valid  (bus.tx_valid),
    .tx_ready  (bus.tx_ready),
    .done      (resp_done)
  );
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a table of command lines with expected
// bus activity and response text, plus reset, backpressure and gap sequences.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  logic clk_48mhz = 1'b0;
  logic reset;
  always #5 clk_48mhz = ~clk_48mhz;

  uart_cmd_parser_if bus ();

  uart_cmd_parser dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .bus       (bus)
  );

  typedef struct {
    string      cmd;
    bit         we;
    bit         re;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdv;
    string      resp;
  } vec_t;

  vec_t vecs[10];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] tx_q[$];
  int         we_cnt, re_cnt;
  logic [7:0] we_addr, we_data, re_addr;
  int         lf_cyc, we_cyc, re_cyc, txv_cyc, tx_hs_cyc, last_acc_cyc;
  logic       txv_d = 1'b0;
  logic [7:0] rd_value = 8'h00;
  logic       re_flag;

  always @(posedge clk_48mhz) cyc <= cyc + 1;

  always @(negedge clk_48mhz) begin
    if (bus.rx_valid && bus.rx_ready && bus.rx_data == LF) lf_cyc = cyc;
    if (bus.tx_valid && bus.tx_ready) begin
      tx_q.push_back(bus.tx_data);
      tx_hs_cyc = cyc;
    end
    if (bus.tx_valid && !txv_d) txv_cyc = cyc;
    txv_d = bus.tx_valid;
    if (bus.reg_we) begin
      we_cnt++;
      we_addr = bus.reg_addr;
      we_data = bus.reg_wdata;
      we_cyc  = cyc;
    end
    if (bus.reg_re) begin
      re_cnt++;
      re_addr = bus.reg_addr;
      re_cyc  = cyc;
    end
  end

  // Read data is only meaningful in the cycle after reg_re; otherwise junk.
  always begin
    @(negedge clk_48mhz);
    re_flag = bus.reg_re;
    @(posedge clk_48mhz);
    #1;
    bus.reg_rdata = re_flag ? rd_value : 8'hEE;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic clear_logs();
    tx_q.delete();
    we_cnt = 0; re_cnt = 0;
    lf_cyc = -100; we_cyc = 0; re_cyc = 0; txv_cyc = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    acc = 1'b0;
    repeat (gap) tick();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk_48mhz);
      if (bus.rx_ready) begin
        acc = 1'b1;
        last_acc_cyc = cyc;
      end
      tick();
    end
    bus.rx_valid = 1'b0;
    if (!acc) check("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp(input int len);
    for (int i = 0; i < 100 && tx_q.size() < len; i++) tick();
    repeat (8) tick();
  endtask

  task automatic check_resp(input string tag, input string resp);
    logic [7:0] got;
    check({tag, "_resp_len"}, tx_q.size(), resp.len());
    for (int i = 0; i < resp.len(); i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      check($sformatf("%s_resp_byte%0d", tag, i), {24'd0, got}, {24'd0, resp[i]});
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    clear_logs();
    rd_value = v.rdv;
    for (int i = 0; i < v.cmd.len(); i++) send_byte(v.cmd[i], 0);
    wait_resp(v.resp.len());
    check({tag, "_we_cnt"}, we_cnt, {31'd0, v.we});
    check({tag, "_re_cnt"}, re_cnt, {31'd0, v.re});
    if (v.we) begin
      check({tag, "_we_addr"}, {24'd0, we_addr}, {24'd0, v.addr});
      check({tag, "_we_data"}, {24'd0, we_data}, {24'd0, v.wdata});
      check({tag, "_we_lat"}, we_cyc - lf_cyc, 32'd1);
      check({tag, "_txv_lat"}, txv_cyc - lf_cyc, 32'd2);
    end
    if (v.re) begin
      check({tag, "_re_addr"}, {24'd0, re_addr}, {24'd0, v.addr});
      check({tag, "_re_lat"}, re_cyc - lf_cyc, 32'd1);
      check({tag, "_txv_lat"}, txv_cyc - lf_cyc, 32'd3);
    end
    check_resp(tag, v.resp);
  endtask

  initial begin
    vec_t  v;
    string gap_cmd;
    logic [7:0] hold_data;
    int    bad_data, bad_rdy;

    vecs[0] = '{"W3Aa5\015\012",          1, 0, 8'h3A, 8'hA5, 8'h00, "K\015\012"};
    vecs[1] = '{"r3a\012",                0, 1, 8'h3A, 8'h00, 8'h7C, "7C\015\012"};
    vecs[2] = '{"WG1\012",                0, 0, 8'h00, 8'h00, 8'h00, "E\015\012"};
    vecs[3] = '{"R123\012",               0, 0, 8'h00, 8'h00, 8'h00, "E\015\012"};
    vecs[4] = '{"X\012",                  0, 0, 8'h00, 8'h00, 8'h00, "E\015\012"};
    vecs[5] = '{"\012",                   0, 0, 8'h00, 8'h00, 8'h00, ""};
    vecs[6] = '{"w00fF\012",              1, 0, 8'h00, 8'hFF, 8'h00, "K\015\012"};
    vecs[7] = '{"R3\012",                 0, 0, 8'h00, 8'h00, 8'h00, "E\015\012"};
    vecs[8] = '{"W12\012",                0, 0, 8'h00, 8'h00, 8'h00, "E\015\012"};
    vecs[9] = '{"\015R\015F\015e\015\012", 0, 1, 8'hFE, 8'h00, 8'hB4, "B4\015\012"};

    reset         = 1'b1;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.tx_ready  = 1'b1;
    bus.reg_rdata = 8'h00;
    clear_logs();
    repeat (3) tick();
    @(negedge clk_48mhz);
    check("rst_rx_ready", bus.rx_ready, 1'b0);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_reg_we", bus.reg_we, 1'b0);
    check("rst_reg_re", bus.reg_re, 1'b0);
    check("rst_reg_addr", bus.reg_addr, 8'h00);
    check("rst_reg_wdata", bus.reg_wdata, 8'h00);
    tick();
    reset = 1'b0;
    @(negedge clk_48mhz);
    check("post_rst_rx_ready", bus.rx_ready, 1'b1);
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stalled read response, then a new command queued behind it.
    clear_logs();
    rd_value     = 8'h7C;
    bus.tx_ready = 1'b0;
    gap_cmd = "R3a\012";
    for (int i = 0; i < gap_cmd.len(); i++) send_byte(gap_cmd[i], 0);
    for (int i = 0; i < 20 && !bus.tx_valid; i++) tick();
    @(negedge clk_48mhz);
    hold_data = bus.tx_data;
    bad_data  = 0;
    bad_rdy   = 0;
    repeat (10) begin
      @(negedge clk_48mhz);
      if (bus.tx_data !== hold_data || !bus.tx_valid) bad_data++;
      if (bus.rx_ready !== 1'b0) bad_rdy++;
    end
    check("bp_first_byte", {24'd0, hold_data}, 32'h37);
    check("bp_data_unstable", bad_data, 0);
    check("bp_rx_ready_high", bad_rdy, 0);
    check("bp_no_early_tx", tx_q.size(), 0);
    tick();
    bus.tx_ready = 1'b1;
    send_byte(CH_R, 0);
    check("bp_accept_after_tx", last_acc_cyc, tx_hs_cyc + 1);
    check_resp("bp_read", "7C\015\012");
    tx_q.delete();
    rd_value = 8'hF0;
    gap_cmd = "00\012";
    for (int i = 0; i < gap_cmd.len(); i++) send_byte(gap_cmd[i], 0);
    wait_resp(4);
    check("bp2_re_cnt", re_cnt, 2);
    check("bp2_re_addr", {24'd0, re_addr}, 32'h00);
    check_resp("bp2_read", "F0\015\012");

    // Write with random idle gaps between bytes.
    clear_logs();
    gap_cmd = "W0102\012";
    for (int i = 0; i < gap_cmd.len(); i++) send_byte(gap_cmd[i], $urandom_range(0, 2));
    wait_resp(3);
    check("gap_we_cnt", we_cnt, 1);
    check("gap_we_addr", {24'd0, we_addr}, 32'h01);
    check("gap_we_data", {24'd0, we_data}, 32'h02);
    check_resp("gap", "K\015\012");

    // Reset in the middle of a write command.
    clear_logs();
    gap_cmd = "W01";
    for (int i = 0; i < gap_cmd.len(); i++) send_byte(gap_cmd[i], 0);
    reset = 1'b1;
    tick();
    @(negedge clk_48mhz);
    check("midrst_reg_addr", bus.reg_addr, 8'h00);
    check("midrst_reg_wdata", bus.reg_wdata, 8'h00);
    check("midrst_rx_ready", bus.rx_ready, 1'b0);
    check("midrst_tx_valid", bus.tx_valid, 1'b0);
    check("midrst_reg_we", bus.reg_we, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    v = '{"R01\012", 0, 1, 8'h01, 8'h00, 8'h3C, "3C\015\012"};
    run_vec(v, "post_rst_read");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
